// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the seven-segment scan controller.
//  - scan_state_t : scan FSM states (IDLE, SHOW, BLANK)
//  - DIGITS       : number of display digits
//  - SEG_0..SEG_F : segment patterns {g,f,e,d,c,b,a}, active high
package display_pkg;

  localparam int DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to seven-segment encoder.
//  nib : in  4  hex value
//  seg : out 7  segments {g,f,e,d,c,b,a}, active high
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a 4-digit
// seven-segment display, with a blanking gap between digits.
//  clk, rst  : clock, synchronous active-high reset
//  en        : scan enable (0 = display dark, scan restarts at digit 0)
//  data_in   : four hex nibbles, [3:0] is digit 0
//  dp_in     : decimal point per digit
//  dig_sel   : current digit index
//  dig_en    : one-hot digit enable, active high
//  seg       : segments {g,f,e,d,c,b,a}, active high
//  dp        : decimal point, active high
//  scan_tick : one-cycle pulse after digit 3's dwell ends
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [1:0]  dig_sel,
  output logic [3:0]  dig_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        scan_tick
);

  localparam int IW = $clog2(DIGITS);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  scan_state_t   state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [15:0]   snap, snap_n;
  logic [3:0]    dp_snap, dp_snap_n;
  logic          tick_n;

  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          lit;
  logic          supp;
  logic [3:0]    dig_en_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  // Next-state logic; outputs are then registered from the next-state
  // values so they line up with the state they describe.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    bcnt_n    = bcnt;
    snap_n    = snap;
    dp_snap_n = dp_snap;
    tick_n    = 1'b0;
    if (!en) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
      bcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = SHOW;
          idx_n     = '0;
          cnt_n     = '0;
          bcnt_n    = '0;
          snap_n    = data_in;
          dp_snap_n = dp_in;
        end
        SHOW: begin
          if (int'(cnt) == CLK_DIV - 1) begin
            cnt_n  = '0;
            bcnt_n = '0;
            tick_n = (idx == IW'(DIGITS - 1));
            if (BLANK_CYCLES == 0) begin
              state_n = SHOW;
              idx_n   = idx + 1'b1;
              if (idx == IW'(DIGITS - 1)) begin
                snap_n    = data_in;
                dp_snap_n = dp_in;
              end
            end else begin
              state_n = BLANK;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (int'(bcnt) == BLANK_CYCLES - 1) begin
            state_n = SHOW;
            idx_n   = idx + 1'b1;
            cnt_n   = '0;
            bcnt_n  = '0;
            if (idx == IW'(DIGITS - 1)) begin
              snap_n    = data_in;
              dp_snap_n = dp_in;
            end
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
          bcnt_n  = '0;
        end
      endcase
    end
  end

  assign nib = snap_n[{idx_n, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nib (nib),
    .seg (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    supp = 1'b0;
    case (idx_n)
      2'd3:    supp = (snap_n[15:12] == '0);
      2'd2:    supp = (snap_n[15:8]  == '0);
      2'd1:    supp = (snap_n[15:4]  == '0);
      default: supp = 1'b0;
    endcase
  end
`else
  assign supp = 1'b0;
`endif

  always_comb begin
    lit      = (state_n == SHOW);
    dig_en_n = '0;
    seg_n    = '0;
    dp_n     = 1'b0;
    if (lit) begin
      dp_n = dp_snap_n[idx_n];
      if (supp) begin
        // A suppressed digit still lights its decimal point if set.
        dig_en_n = dp_n ? (4'b0001 << idx_n) : 4'b0000;
      end else begin
        dig_en_n = 4'b0001 << idx_n;
        seg_n    = seg_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      bcnt      <= '0;
      snap      <= '0;
      dp_snap   <= '0;
      dig_sel   <= '0;
      dig_en    <= '0;
      seg       <= '0;
      dp        <= 1'b0;
      scan_tick <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      bcnt      <= bcnt_n;
      snap      <= snap_n;
      dp_snap   <= dp_snap_n;
      dig_sel   <= idx_n;
      dig_en    <= dig_en_n;
      seg       <= seg_n;
      dp        <= dp_n;
      scan_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed bench for display_scan_ctrl. Two instances
// share the inputs: u_dut2 (CLK_DIV=4, BLANK_CYCLES=2) and u_dut0
// (CLK_DIV=4, BLANK_CYCLES=0). Outputs are compared as a packed vector
// {dig_sel, dig_en, seg, dp, scan_tick}.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] data_in;
  logic [3:0]  dp_in;

  logic [1:0]  dig_sel2, dig_sel0;
  logic [3:0]  dig_en2, dig_en0;
  logic [6:0]  seg2, seg0;
  logic        dp2, dp0, tick2, tick0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  display_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_in(dp_in),
    .dig_sel(dig_sel2), .dig_en(dig_en2), .seg(seg2), .dp(dp2), .scan_tick(tick2)
  );

  display_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_in(dp_in),
    .dig_sel(dig_sel0), .dig_en(dig_en0), .seg(seg0), .dp(dp0), .scan_tick(tick0)
  );

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] obs(input bit sel0);
    return sel0 ? {dig_sel0, dig_en0, seg0, dp0, tick0}
                : {dig_sel2, dig_en2, seg2, dp2, tick2};
  endfunction

  // Expected SHOW output of digit k for snapshot d/dv (tick bit excluded).
  function automatic logic [14:0] show_exp(input int k, input logic [15:0] d, input logic [3:0] dv);
    logic [3:0] nibv;
    logic [6:0] s;
    logic [3:0] e;
    logic       p;
    logic [1:0] ks;
    nibv = d[k*4 +: 4];
    s    = segtab[nibv];
    e    = 4'b0001 << k;
    p    = dv[k];
    ks   = 2'(k);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (d >> (4 * k)) == 16'h0000) begin
      s = 7'h00;
      e = p ? (4'b0001 << k) : 4'b0000;
    end
`endif
    return {ks, e, s, p, 1'b0};
  endfunction

  // Walk one full frame cycle by cycle. "first" means no preceding frame
  // (so no tick on the first cycle for a zero-gap instance). When chg is
  // set, data_in changes to chg_d during digit 1.
  task automatic run_frame(input string tag, input bit sel0, input logic [15:0] d,
                           input logic [3:0] dv, input bit first,
                           input bit chg, input logic [15:0] chg_d);
    int nb;
    logic [14:0] ev;
    nb = sel0 ? 0 : 2;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (chg && k == 1 && c == 1) data_in = chg_d;
        ev = show_exp(k, d, dv);
        ev[0] = (!first && nb == 0 && k == 0 && c == 0);
        check(tag, obs(sel0), ev);
      end
      for (int b = 0; b < nb; b++) begin
        @(negedge clk);
        ev = {2'(k), 4'b0000, 7'h00, 1'b0, 1'(k == 3 && b == 0)};
        check({tag, "_blank"}, obs(sel0), ev);
      end
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_a"}, obs(1'b0), 15'h0000);
      check({tag, "_b"}, obs(1'b1), 15'h0000);
    end
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    data_in = 16'h0000;
    dp_in   = 4'b0000;
    skip(3);
    check("reset", obs(1'b0), 15'h0000);
    rst = 1'b0;
    idle_cycles("idle_dark", 10);

    // Basic frames, then mid-frame data change taking effect next frame.
    data_in = 16'h1234;
    dp_in   = 4'b0100;
    en      = 1'b1;
    run_frame("f1234", 1'b0, 16'h1234, 4'b0100, 1'b1, 1'b0, 16'h0);
    run_frame("f1234b", 1'b0, 16'h1234, 4'b0100, 1'b0, 1'b1, 16'hABCD);
    run_frame("fabcd", 1'b0, 16'hABCD, 4'b0100, 1'b0, 1'b0, 16'h0);

    // Drop en during SHOW of digit 2.
    skip(12);
    @(negedge clk);
    check("pre_drop", obs(1'b0), show_exp(2, 16'hABCD, 4'b0100));
    en = 1'b0;
    idle_cycles("en_drop", 2);
    data_in = 16'h5678;
    dp_in   = 4'b0001;
    en      = 1'b1;
    run_frame("f5678", 1'b0, 16'h5678, 4'b0001, 1'b1, 1'b0, 16'h0);

    // Same, with reset in place of dropping en.
    skip(12);
    @(negedge clk);
    check("pre_rst", obs(1'b0), show_exp(2, 16'h5678, 4'b0001));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_a", obs(1'b0), 15'h0000);
    check("mid_rst_b", obs(1'b1), 15'h0000);
    rst     = 1'b0;
    data_in = 16'h9ABC;
    dp_in   = 4'b1000;
    run_frame("f9abc", 1'b0, 16'h9ABC, 4'b1000, 1'b1, 1'b0, 16'h0);

    // Zero-gap instance: back-to-back digits, 16-cycle frame.
    rst = 1'b1;
    en  = 1'b0;
    skip(2);
    rst     = 1'b0;
    data_in = 16'h000F;
    dp_in   = 4'b0000;
    en      = 1'b1;
    run_frame("nb_f1", 1'b1, 16'h000F, 4'b0000, 1'b1, 1'b0, 16'h0);
    run_frame("nb_f2", 1'b1, 16'h000F, 4'b0000, 1'b0, 1'b0, 16'h0);

    // Leading zeros, with and without dp on a leading digit.
    en = 1'b0;
    skip(2);
    data_in = 16'h0040;
    dp_in   = 4'b0000;
    en      = 1'b1;
    run_frame("lz", 1'b0, 16'h0040, 4'b0000, 1'b1, 1'b0, 16'h0);
    en = 1'b0;
    skip(2);
    dp_in = 4'b1000;
    en    = 1'b1;
    run_frame("lz_dp", 1'b0, 16'h0040, 4'b1000, 1'b1, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
